aes_128_key_inv: RTL and testbench
==================================

// Module: aes_128_key_inv
// PURPOSE
//  Inverse AES-128 key schedule for the decryption datapath. Loads the final (round-10) key and
//  walks the schedule backwards, streaming round keys 10,9,...,0 (decryption order) one per cycle.
//  Uses one shared 4-byte S-box word instead of a full 11-key register bank.
//  Sits between key load and the inverse-cipher round engine.
// PARAMETERS
//  EQ_INV   0   1: rk_o for idx 9..1 is InvMixColumns(raw key), for the equivalent inverse cipher;
//               idx 10 and 0 are always raw. 0: all keys raw.
// PORTS
//  clk         in   1    clock
//  rst         in   1    synchronous reset, active-high
//  key_vld_i   in   1    key load request
//  key_i       in   128  round-10 key; word w0 = [127:96] ... w3 = [31:0]
//  key_rdy_o   out  1    block idle, load accepted when key_vld_i & key_rdy_o
//  rk_vld_o    out  1    round key valid
//  rk_rdy_i    in   1    consumer ready
//  rk_o        out  128  round key, same word order as key_i
//  rk_idx_o    out  4    round index of rk_o, 10 down to 0
//  rk_last_o   out  1    high with rk_idx_o==0
// BEHAVIOUR
//  - Reset: rk_vld_o=0, rk_o=0, rk_idx_o=0, rk_last_o=0; state IDLE. key_rdy_o=0 while rst is high.
//    key_rdy_o=1 in the first cycle after rst falls.
//  - FSM IDLE->RUN: on load handshake at edge t, register key_i, idx=10. rk_vld_o=1 from t+1.
//  - key_rdy_o = (state==IDLE). key_vld_i is ignored in RUN; no load during a stream.
//  - RUN, output handshake (rk_vld_o & rk_rdy_i):
//    - idx>0: replace the register with the previous key, idx-=1.
//    - idx==0: ->IDLE; rk_vld_o=0 and key_rdy_o=1 next cycle.
//  - Backpressure: while rk_vld_o & !rk_rdy_i, rk_o, rk_idx_o and rk_last_o hold stable.
//    rk_vld_o stays high until the handshake.
//  - Throughput 1 key/cycle with rk_rdy_i tied high. Stream = 11 cycles, then one IDLE cycle.
//  - Inverse step from K_i = {w0,w1,w2,w3} (i = idx) to K_(i-1) = {p0,p1,p2,p3}:
//    - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
//    - p0 = w0 ^ SubWord(RotWord(p3)) ^ {RCON[i],24'h0}.
//    - RotWord({a,b,c,d}) = {b,c,d,a}.
//    - RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
//  - rk_o is combinational from the key register. With EQ_INV=1 it goes through the InvMixColumns
//    mux; there is no extra pipeline stage.
//  - Reset mid-stream: return to IDLE at once, outputs to reset values, partial stream dropped.
// STRUCTURE
//  - aes_pkg: AES_NR=10, RCON table (8-bit x 10, indexed 1..10), typedef aes_word_t (32b),
//    typedef aes_key_t (128b).
//  - Four aes_sbox instances on p3, reusing the existing S-box.
//  - Sub-module aes_inv_mix_col (32b column in/out), 4 instances, generated only when EQ_INV=1.
// TESTING
//  1 FIPS-197 A.1: key_i=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_rdy_i=1:
//    idx10=d014f9a8c9ee2589e13f0cc8b6630ca6, idx9=ac7766f319fadc2128d12941575c006e,
//    idx0=2b7e151628aed2a6abf7158809cf4f3c with rk_last_o=1; 11 consecutive valid cycles.
//  2 Backpressure: same key, rk_rdy_i low for 3 cycles at idx 9 -> rk_o and rk_idx_o hold 9
//    unchanged; stream resumes with no skip or duplicate.
//  3 Load during RUN: pulse key_vld_i with a different key at idx 5 -> ignored, key_rdy_o=0,
//    stream completes unchanged; key_rdy_o=1 the cycle after idx0 handshake.
//  4 Reset at idx 4 -> next cycle rk_vld_o=0, rk_o=0; after release key_rdy_o=1 and a fresh
//    load streams from idx 10 correctly.
//  5 Round-trip: 100 random cipher keys expanded by aes_128_key; feed its round-10 output ->
//    every rk_o at idx i equals the forward round key i.
//  6 EQ_INV=1: idx 10 and 0 raw; idx 1..9 equal InvMixColumns of the scenario-1 keys.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, round constants and GF(2^8) helpers for the key-schedule slice.
package aes_pkg;
    localparam int AES_NR = 10;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;

    localparam logic [7:0] RCON [1:AES_NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // Round constant for round i; rounds outside 1..AES_NR contribute nothing.
    function automatic logic [7:0] aes_rcon(input logic [3:0] i);
        logic [7:0] r;
        r = '0;
        for (int k = 1; k <= AES_NR; k++) begin
            if (i == 4'(k)) r = RCON[k];
        end
        return r;
    endfunction
endpackage

// File: rtl/aes_inv_mix_col.sv
// InvMixColumns on one 32-bit state column, byte 0 in bits [31:24].
module aes_inv_mix_col
    import aes_pkg::*;
(
    input  aes_word_t col,
    output aes_word_t mixed
);
    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col;

    assign mixed[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mixed[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mixed[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mixed[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] sq;
    logic [7:0] inv;

    // a^254 by square-and-multiply; zero maps to zero as required.
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_128_key_inv.sv
// Inverse AES-128 key schedule: loads the round-10 key and streams round keys 10..0,
// deriving each previous key on the fly from a single key register.
module aes_128_key_inv
    import aes_pkg::*;
#(
    parameter bit EQ_INV = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_vld_i,
    input  aes_key_t   key_i,
    output logic       key_rdy_o,
    output logic       rk_vld_o,
    input  logic       rk_rdy_i,
    output aes_key_t   rk_o,
    output logic [3:0] rk_idx_o,
    output logic       rk_last_o
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    aes_key_t   key_q;
    logic [3:0] idx_q;
    logic       vld_q;

    aes_word_t  w0, w1, w2, w3;
    aes_word_t  p0, p1, p2, p3;
    aes_word_t  rot;
    aes_word_t  sub;
    aes_key_t   prev_key;

    assign {w0, w1, w2, w3} = key_q;
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};
    assign p0  = w0 ^ sub ^ {aes_rcon(idx_q), 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*g +: 8]),
            .y (sub[8*g +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vld_q <= 1'b0;
            key_q <= '0;
            idx_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_vld_i) begin
                        state <= RUN;
                        vld_q <= 1'b1;
                        key_q <= key_i;
                        idx_q <= 4'(AES_NR);
                    end
                end
                RUN: begin
                    if (rk_rdy_i) begin
                        if (idx_q == 4'd0) begin
                            state <= IDLE;
                            vld_q <= 1'b0;
                        end else begin
                            key_q <= prev_key;
                            idx_q <= idx_q - 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_rdy_o = (state == IDLE) && !rst;
    assign rk_vld_o  = vld_q;
    assign rk_idx_o  = idx_q;
    assign rk_last_o = vld_q && (idx_q == 4'd0);

    // The first and last keys feed AddRoundKey directly, so they bypass InvMixColumns.
    if (EQ_INV) begin : g_eq
        aes_key_t imc;
        for (genvar c = 0; c < 4; c++) begin : g_col
            aes_inv_mix_col u_imc (
                .col   (key_q[32*c +: 32]),
                .mixed (imc[32*c +: 32])
            );
        end
        assign rk_o = (idx_q != 4'd0 && idx_q != 4'(AES_NR)) ? imc : key_q;
    end else begin : g_raw
        assign rk_o = key_q;
    end
endmodule

// File: tb/tb_aes_128_key_inv.sv
// Bench for aes_128_key_inv: forward-expansion reference model with a per-cycle compare process.
module tb_aes_128_key_inv;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_vld_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         rk_rdy_i = 1'b0;

    logic         key_rdy_o, rk_vld_o, rk_last_o;
    logic [127:0] rk_o;
    logic [3:0]   rk_idx_o;
    logic         e_key_rdy_o, e_rk_vld_o, e_rk_last_o;
    logic [127:0] e_rk_o;
    logic [3:0]   e_rk_idx_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic [127:0] pend_tab [11];
    logic [127:0] m_keys [11];
    bit           m_busy = 1'b0;
    int           m_idx = 0;

    aes_128_key_inv #(.EQ_INV(1'b0)) dut (
        .clk(clk), .rst(rst), .key_vld_i(key_vld_i), .key_i(key_i), .key_rdy_o(key_rdy_o),
        .rk_vld_o(rk_vld_o), .rk_rdy_i(rk_rdy_i), .rk_o(rk_o), .rk_idx_o(rk_idx_o),
        .rk_last_o(rk_last_o)
    );

    aes_128_key_inv #(.EQ_INV(1'b1)) dut_eq (
        .clk(clk), .rst(rst), .key_vld_i(key_vld_i), .key_i(key_i), .key_rdy_o(e_key_rdy_o),
        .rk_vld_o(e_rk_vld_o), .rk_rdy_i(rk_rdy_i), .rk_o(e_rk_o), .rk_idx_o(e_rk_idx_o),
        .rk_last_o(e_rk_last_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box table from the generator-3 walk: p steps by *3, q by /3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ t;
            t = (t << 1) ^ (t[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] c);
        logic [7:0] m [4][4];
        logic [7:0] a [4];
        logic [31:0] r;
        m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
              '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        a = '{c[31:24], c[23:16], c[15:8], c[7:0]};
        r = '0;
        for (int row = 0; row < 4; row++) begin
            logic [7:0] acc;
            acc = '0;
            for (int k = 0; k < 4; k++) acc = acc ^ mul(a[k], m[row][k]);
            r[8*(3-row) +: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] imc_key(input logic [127:0] k);
        return {imc_col(k[127:96]), imc_col(k[95:64]), imc_col(k[63:32]), imc_col(k[31:0])};
    endfunction

    // Forward FIPS-197 expansion of a cipher key into pend_tab[0..10].
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) pend_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Reference model: tracks handshakes from the bench's own stimulus.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_idx  = 0;
        end else if (!m_busy) begin
            if (key_vld_i) begin
                m_busy = 1'b1;
                m_idx  = 10;
                m_keys = pend_tab;
            end
        end else if (rk_rdy_i) begin
            if (m_idx == 0) m_busy = 1'b0;
            else m_idx--;
        end
    end

    always @(negedge clk) begin
        check("key_rdy", 128'(key_rdy_o), 128'(!m_busy && !rst));
        check("rk_vld", 128'(rk_vld_o), 128'(m_busy));
        check("eq_key_rdy", 128'(e_key_rdy_o), 128'(!m_busy && !rst));
        check("eq_rk_vld", 128'(e_rk_vld_o), 128'(m_busy));
        if (m_busy) begin
            check("rk_idx", 128'(rk_idx_o), 128'(m_idx));
            check("rk_last", 128'(rk_last_o), 128'(m_idx == 0));
            check("rk", rk_o, m_keys[m_idx]);
            check("eq_rk_idx", 128'(e_rk_idx_o), 128'(m_idx));
            check("eq_rk_last", 128'(e_rk_last_o), 128'(m_idx == 0));
            check("eq_rk", e_rk_o,
                  (m_idx == 0 || m_idx == 10) ? m_keys[m_idx] : imc_key(m_keys[m_idx]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k0);
        expand(k0);
        key_i     = pend_tab[10];
        key_vld_i = 1'b1;
        step();
        key_vld_i = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            step();
            n++;
        end
        check("stream_done_in_budget", 128'(m_busy), 128'(0));
    endtask

    task automatic run_until_idx(input int target, input int budget);
        int n;
        n = 0;
        while (m_busy && m_idx != target && n < budget) begin
            step();
            n++;
        end
        check("reached_idx", 128'(m_idx), 128'(target));
    endtask

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;

    initial begin
        int n;
        build_sbox();

        // Pin the model against published vectors.
        expand(K0);
        check("model_k10", pend_tab[10], K10);
        check("model_k9", pend_tab[9], K9);
        check("model_imc", 128'(imc_col(32'h8e4da1bc)), 128'(32'hdb135345));

        repeat (3) step();
        check("rst_rk", rk_o, 128'h0);
        check("rst_idx", 128'(rk_idx_o), 128'h0);
        check("rst_last", 128'(rk_last_o), 128'h0);
        check("rst_key_rdy", 128'(key_rdy_o), 128'h0);
        rst = 1'b0;
        step();
        check("key_rdy_after_rst", 128'(key_rdy_o), 128'h1);

        // Scenario 1: FIPS-197 key, consumer always ready.
        rk_rdy_i = 1'b1;
        load(K0);
        check("s1_k10", rk_o, K10);
        check("s1_eq_k10_raw", e_rk_o, K10);
        n = 0;
        while (rk_vld_o && n < 20) begin
            if (rk_idx_o == 4'd9) check("s1_k9", rk_o, K9);
            if (rk_idx_o == 4'd0) begin
                check("s1_k0", rk_o, K0);
                check("s1_eq_k0_raw", e_rk_o, K0);
                check("s1_last", 128'(rk_last_o), 128'h1);
            end
            n++;
            step();
        end
        check("s1_valid_cycles", 128'(n), 128'd11);
        check("s1_key_rdy_after", 128'(key_rdy_o), 128'h1);
        step();

        // Scenario 2: backpressure at idx 9.
        load(K0);
        step();
        rk_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s2_hold_idx", 128'(rk_idx_o), 128'd9);
            check("s2_hold_rk", rk_o, K9);
            check("s2_hold_vld", 128'(rk_vld_o), 128'h1);
        end
        rk_rdy_i = 1'b1;
        run_until_idle(30);
        step();

        // Scenario 3: load attempt during a stream is ignored.
        load(K0);
        run_until_idx(5, 20);
        check("s3_key_rdy_busy", 128'(key_rdy_o), 128'h0);
        key_i     = 128'h00112233445566778899aabbccddeeff;
        key_vld_i = 1'b1;
        step();
        key_vld_i = 1'b0;
        run_until_idle(30);
        check("s3_key_rdy_end", 128'(key_rdy_o), 128'h1);
        step();

        // Scenario 4: reset mid-stream at idx 4, then a fresh load.
        load(K0);
        run_until_idx(4, 20);
        rst = 1'b1;
        step();
        check("s4_rk_vld", 128'(rk_vld_o), 128'h0);
        check("s4_rk", rk_o, 128'h0);
        check("s4_idx", 128'(rk_idx_o), 128'h0);
        rst = 1'b0;
        step();
        check("s4_key_rdy", 128'(key_rdy_o), 128'h1);
        load(K0);
        check("s4_fresh_idx", 128'(rk_idx_o), 128'd10);
        check("s4_fresh_rk", rk_o, K10);
        run_until_idle(30);
        step();

        // Scenario 5: random cipher keys with random consumer stalls.
        for (int t = 0; t < 100; t++) begin
            rk_rdy_i = 1'b1;
            load({$urandom, $urandom, $urandom, $urandom});
            n = 0;
            while (m_busy && n < 100) begin
                rk_rdy_i = ($urandom_range(0, 3) != 0);
                step();
                n++;
            end
            check("s5_done_in_budget", 128'(m_busy), 128'(0));
            rk_rdy_i = 1'b1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
